// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage: write-back source encodings,
// the hard-wired zero register index and the bubble instruction encoding.
package wb_pkg;

    typedef logic [1:0] wb_sel_t;

    localparam wb_sel_t     WB_SEL_ALU   = 2'b00;
    localparam wb_sel_t     WB_SEL_DM    = 2'b01;
    localparam wb_sel_t     WB_SEL_PC    = 2'b10;
    localparam wb_sel_t     WB_SEL_RSV   = 2'b11;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

endpackage

// File: rtl/rf_2r1w.sv
// General register file: async-reset array, one synchronous write port and two
// asynchronous read ports. Define RF_BYPASS_EN for write-through reads.
module rf_2r1w
    import wb_pkg::*;
#(
    parameter  int NREG = 32,
    parameter  int DW   = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] regs [NREG];

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != AW'(REG_ZERO))) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs[raddr_a];
`ifdef RF_BYPASS_EN
        if (we && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
`endif
        if (raddr_a == AW'(REG_ZERO)) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = regs[raddr_b];
`ifdef RF_BYPASS_EN
        if (we && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
`endif
        if (raddr_b == AW'(REG_ZERO)) begin
            rdata_b = '0;
        end
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: source select, register-file commit, ID read ports and a
// retired-instruction counter. RF_BYPASS_EN enables write-through register reads.
module wb_stage_regfile
    import wb_pkg::*;
#(
    parameter  int NREG  = 32,
    parameter  int DW    = 32,
    parameter  int CNT_W = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    WB_DmResult,
    input  logic [DW-1:0]    WB_AluOut,
    input  logic [DW-1:2]    WB_PcAddOne,
    input  logic [1:0]       WB_WbSel,
    input  logic [AW-1:0]    WB_Rw,
    input  logic             WB_RfWr,
    input  logic [DW-1:0]    WB_Instr,
    input  logic [AW-1:0]    ID_Ra,
    input  logic [AW-1:0]    ID_Rb,
    output logic [DW-1:0]    ID_BusA,
    output logic [DW-1:0]    ID_BusB,
    output logic [DW-1:0]    WB_BusW,
    output logic             WB_WrEff,
    output logic [CNT_W-1:0] RetireCnt
);

    always_comb begin
        WB_BusW = '0;
        case (WB_WbSel)
            WB_SEL_ALU: WB_BusW = WB_AluOut;
            WB_SEL_DM:  WB_BusW = WB_DmResult;
            WB_SEL_PC:  WB_BusW = {WB_PcAddOne, 2'b00};
            default:    WB_BusW = '0;
        endcase
    end

    // The reserved select also kills the write so a bad decode cannot corrupt state.
    assign WB_WrEff = WB_RfWr
                    & (WB_Rw != AW'(REG_ZERO))
                    & (WB_WbSel != WB_SEL_RSV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RetireCnt <= '0;
        end else if (WB_Instr != DW'(BUBBLE_INSTR)) begin
            RetireCnt <= RetireCnt + CNT_W'(1);
        end
    end

    rf_2r1w #(
        .NREG (NREG),
        .DW   (DW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (WB_WrEff),
        .waddr   (WB_Rw),
        .wdata   (WB_BusW),
        .raddr_a (ID_Ra),
        .raddr_b (ID_Rb),
        .rdata_a (ID_BusA),
        .rdata_b (ID_BusB)
    );

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Self-checking bench for wb_stage_regfile: directed cases plus a randomized run
// against a behavioural register-file model. Honours RF_BYPASS_EN.
module tb_wb_stage_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dm = '0;
    logic [31:0] alu = '0;
    logic [31:2] pc = '0;
    logic [1:0]  sel = '0;
    logic [4:0]  rw = '0;
    logic        rfwr = 1'b0;
    logic [31:0] instr = '0;
    logic [4:0]  ra = '0;
    logic [4:0]  rb = '0;

    logic [31:0] bus_a, bus_b, bus_w;
    logic        wr_eff;
    logic [31:0] retire_cnt;

    logic [31:0] bus_a4, bus_b4, bus_w4;
    logic        wr_eff4;
    logic [3:0]  retire_cnt4;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] ref_gpr [32];
    int unsigned ref_cnt;

    always #5 clk = ~clk;

    wb_stage_regfile dut (
        .clk(clk), .rst(rst),
        .WB_DmResult(dm), .WB_AluOut(alu), .WB_PcAddOne(pc), .WB_WbSel(sel),
        .WB_Rw(rw), .WB_RfWr(rfwr), .WB_Instr(instr),
        .ID_Ra(ra), .ID_Rb(rb),
        .ID_BusA(bus_a), .ID_BusB(bus_b), .WB_BusW(bus_w), .WB_WrEff(wr_eff),
        .RetireCnt(retire_cnt)
    );

    // Narrow-counter instance shares all stimulus; only its counter is checked.
    wb_stage_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .WB_DmResult(dm), .WB_AluOut(alu), .WB_PcAddOne(pc), .WB_WbSel(sel),
        .WB_Rw(rw), .WB_RfWr(rfwr), .WB_Instr(instr),
        .ID_Ra(ra), .ID_Rb(rb),
        .ID_BusA(bus_a4), .ID_BusB(bus_b4), .WB_BusW(bus_w4), .WB_WrEff(wr_eff4),
        .RetireCnt(retire_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_busw();
        case (int'(sel))
            0:       return alu;
            1:       return dm;
            2:       return 32'(pc) * 32'd4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_wr();
        return rfwr && (rw != 5'd0) && (sel != 2'd3);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (model_wr() && addr == rw) return model_busw();
`endif
        return ref_gpr[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
        ref_cnt = 0;
    endtask

    // Inputs already driven (edge+1); compare comb outputs at edge+3, then clock.
    task automatic step();
        #2;
        check("busw",   bus_w, model_busw());
        check("wreff",  {31'b0, wr_eff}, {31'b0, model_wr()});
        check("busa",   bus_a, model_read(ra));
        check("busb",   bus_b, model_read(rb));
        check("retire", retire_cnt, ref_cnt);
        @(posedge clk);
        if (model_wr()) ref_gpr[rw] = model_busw();
        if (instr != 32'h0) ref_cnt++;
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                         input logic [29:0] p, input logic [4:0] w, input logic we,
                         input logic [31:0] ins, input logic [4:0] xa, input logic [4:0] xb);
        sel = s; alu = a; dm = d; pc = p; rw = w; rfwr = we; instr = ins; ra = xa; rb = xb;
    endtask

    task automatic idle();
        drive(2'd0, 32'h0, 32'h0, 30'h0, 5'd0, 1'b0, 32'h0, ra, rb);
    endtask

    // Reset with a write to R5 presented: it must not land.
    task automatic do_reset();
        drive(2'd0, 32'hFFFF_FFFF, 32'h0, 30'h0, 5'd5, 1'b1, 32'h1, 5'd5, 5'd6);
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_busa", bus_a, 32'h0);
        check("rst_busb", bus_b, 32'h0);
        check("rst_cnt",  retire_cnt, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        #1;
        check("rst_nowr", bus_a, 32'h0);
        check("rst_cnt4", {28'b0, retire_cnt4}, 32'h0);
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Each write source, then read back a cycle later.
        drive(2'd0, 32'h1234_5678, 32'h0, 30'h0, 5'd5, 1'b1, 32'h1, 5'd1, 5'd2);
        step();
        drive(2'd1, 32'h0, 32'hDEAD_BEEF, 30'h0, 5'd6, 1'b1, 32'h2, 5'd5, 5'd0);
        step();
        drive(2'd2, 32'h0, 32'h0, 30'h0000_1001, 5'd31, 1'b1, 32'h3, 5'd6, 5'd5);
        step();
        idle(); ra = 5'd5; rb = 5'd6;
        #1;
        check("r5_alu", bus_a, 32'h1234_5678);
        check("r6_dm",  bus_b, 32'hDEAD_BEEF);
        ra = 5'd31;
        #1;
        check("r31_pc", bus_a, 32'h0000_4004);
        #1;
        @(posedge clk); #1;

        // Writes to R0 and with the reserved select are dropped.
        drive(2'd0, 32'hFFFF_FFFF, 32'h0, 30'h0, 5'd0, 1'b1, 32'h4, 5'd0, 5'd7);
        #1;
        check("r0_wreff", {31'b0, wr_eff}, 32'h0);
        step();
        drive(2'd3, 32'h7777_7777, 32'h7777_7777, 30'h3FFF_FFFF, 5'd7, 1'b1, 32'h5, 5'd0, 5'd7);
        #1;
        check("rsv_busw",  bus_w, 32'h0);
        check("rsv_wreff", {31'b0, wr_eff}, 32'h0);
        step();
        idle(); ra = 5'd0; rb = 5'd7;
        #1;
        check("r0_read", bus_a, 32'h0);
        check("r7_keep", bus_b, 32'h0);

        // Same-cycle write/read collision on R9.
        drive(2'd0, 32'h1, 32'h0, 30'h0, 5'd9, 1'b1, 32'h6, 5'd0, 5'd0);
        step();
        drive(2'd0, 32'hA5A5_A5A5, 32'h0, 30'h0, 5'd9, 1'b1, 32'h7, 5'd9, 5'd9);
        #1;
`ifdef RF_BYPASS_EN
        check("coll_a", bus_a, 32'hA5A5_A5A5);
        check("coll_b", bus_b, 32'hA5A5_A5A5);
`else
        check("coll_a", bus_a, 32'h1);
        check("coll_b", bus_b, 32'h1);
`endif
        step();

        // Retire counting: 10 cycles with 4 bubbles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(2'd0, 32'h0, 32'h0, 30'h0, 5'd0, 1'b0, (i % 5 < 2) ? 32'h0 : 32'h13, 5'd0, 5'd0);
            step();
        end
        idle();
        #1;
        check("retire6", retire_cnt, 32'd6);

        // 17 retirements: wide counter reads 17, 4-bit counter wraps to 1.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(2'd0, 32'h0, 32'h0, 30'h0, 5'd0, 1'b0, 32'hFFFF_FFFF, 5'd0, 5'd0);
            step();
        end
        idle();
        #1;
        check("retire17", retire_cnt, 32'd17);
        check("wrap4",    {28'b0, retire_cnt4}, 32'd1);

        // Randomized regression against the model.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            logic [4:0] w;
            w = 5'($urandom_range(0, 31));
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, 30'($urandom),
                  w, 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1),
                  ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)));
            step();
        end
        idle();
        #1;
        check("rand_cnt4", {28'b0, retire_cnt4}, ref_cnt % 16);
        for (int r = 0; r < 32; r++) begin
            ra = 5'(r);
            #1;
            check("final_gpr", bus_a, model_read(ra));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
